// File: rtl/reg_file_sb_if.sv
// ---------------------------------------------------------------------------
// reg_file_sb_if
// Bundles the read, write, allocate and clear signals of the scoreboarded
// register file so that the file and its user connect through one port.
//
// Parameters:
//   XLEN  - register width in bits
//   NREGS - register count (power of two, >= 4)
//   NRD   - number of read ports (1..4)
//
// Signals:
//   rd_addr    NRD*AW    read addresses; port i at [i*AW +: AW]
//   rd_data    NRD*XLEN  read data; port i at [i*XLEN +: XLEN]
//   rd_busy    NRD       scoreboard busy bit for each read address
//   wr_en      1         write strobe
//   wr_addr    AW        write address
//   wr_data    XLEN      write data
//   alloc_en   1         mark a destination register pending
//   alloc_addr AW        register to mark pending
//   clr_req    1         start a full-file clear sweep
//   ready      1         file is idle and accepts writes/allocs
//   clr_done   1         one-cycle pulse when a sweep completes
//
// Modports:
//   master - the user of the register file (drives addresses and strobes)
//   slave  - the register file itself
// ---------------------------------------------------------------------------
interface reg_file_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                alloc_en;
  logic [AW-1:0]       alloc_addr;
  logic                clr_req;
  logic                ready;
  logic                clr_done;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, clr_req,
    input  rd_data, rd_busy, ready, clr_done
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, clr_req,
    output rd_data, rd_busy, ready, clr_done
  );
endinterface

// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb
// Register file with a per-register scoreboard busy bit and a clear sweep.
// Reads are combinational on NRD ports. A write stores data and clears the
// busy bit, an allocate sets it (allocate wins on a same-address collision).
// Register 0 is hard-wired to zero and never busy. A clear sweep zeroes one
// register per cycle, index 0 to NREGS-1; reset always starts such a sweep,
// and ready stays low until it finishes.
//
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - asynchronous active-high reset
//   bus  - reg_file_sb_if slave modport (read ports, write, alloc, clear,
//          ready and clr_done)
//
// Configuration:
//   REG_FILE_SB_BYPASS_EN - when defined, a write in the current cycle is
//   forwarded to any read port addressing the same register. When undefined,
//   the new value appears the cycle after the write.
// ---------------------------------------------------------------------------
module reg_file_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
) (
  input logic          clk,
  input logic          rst,
  reg_file_sb_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t          r_state;
  logic            r_ready;
  logic            r_clrDone;
  logic [AW-1:0]   r_sweepIdx;
  logic [NREGS-1:0] r_busy;
  logic [XLEN-1:0] r_regs [NREGS];

  logic w_wrOk;
  logic w_allocOk;

  // Writes and allocates are only honoured while idle, and never to r0.
  assign w_wrOk    = r_ready && bus.wr_en    && (bus.wr_addr    != '0);
  assign w_allocOk = r_ready && bus.alloc_en && (bus.alloc_addr != '0);

  // Control FSM plus scoreboard. ready mirrors the IDLE state but is kept as
  // its own flop so the output is registered. In IDLE the write clears busy
  // first and the allocate sets it afterwards, so the allocate wins when both
  // hit the same register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= CLEAR;
      r_ready    <= 1'b0;
      r_clrDone  <= 1'b0;
      r_sweepIdx <= '0;
      r_busy     <= '0;
    end else begin
      r_clrDone <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_wrOk) begin
            r_busy[bus.wr_addr] <= 1'b0;
          end
          if (w_allocOk) begin
            r_busy[bus.alloc_addr] <= 1'b1;
          end
          if (bus.clr_req) begin
            r_state    <= CLEAR;
            r_ready    <= 1'b0;
            r_sweepIdx <= '0;
          end
        end
        CLEAR: begin
          r_busy[r_sweepIdx] <= 1'b0;
          if (r_sweepIdx == AW'(NREGS - 1)) begin
            r_state    <= IDLE;
            r_ready    <= 1'b1;
            r_clrDone  <= 1'b1;
            r_sweepIdx <= '0;
          end else begin
            r_sweepIdx <= r_sweepIdx + AW'(1);
          end
        end
        default: begin
          r_state <= CLEAR;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Data array. It has no reset of its own: the sweep that follows every
  // reset is what brings the contents to zero.
  always_ff @(posedge clk) begin
    if (r_state == CLEAR) begin
      r_regs[r_sweepIdx] <= '0;
    end else if (w_wrOk) begin
      r_regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // One combinational read path per port. Address 0 is forced to zero rather
  // than read from the array, because the array is undefined before the
  // first sweep completes.
  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_data;
    logic            w_busy;

    assign w_addr = bus.rd_addr[g*AW +: AW];

    always_comb begin
      w_data = '0;
      w_busy = 1'b0;
      if (w_addr != '0) begin
        w_data = r_regs[w_addr];
        w_busy = r_busy[w_addr];
`ifdef REG_FILE_SB_BYPASS_EN
        if (w_wrOk && (bus.wr_addr == w_addr)) begin
          w_data = bus.wr_data;
          w_busy = w_allocOk && (bus.alloc_addr == w_addr);
        end
`endif
      end
    end

    assign bus.rd_data[g*XLEN +: XLEN] = w_data;
    assign bus.rd_busy[g]              = w_busy;
  end

  assign bus.ready    = r_ready;
  assign bus.clr_done = r_clrDone;

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32: register width in bits.
REQ-002 SHALL have parameter NREGS, default 32: register count, power of two, >= 4; AW = log2(NREGS).
REQ-003 SHALL have parameter NRD, default 2: number of read ports, 1..4.
REQ-004 SHALL have one clock, clk; reset is asynchronous and active-high, rst.
REQ-005 Ports, one per line:
  clk  in  1  clock; all state updates on posedge.
  rst  in  1  asynchronous active-high reset.
  rd_addr  in  NRD*AW  read addresses; port i at bits [i*AW +: AW].
  rd_data  out  NRD*XLEN  read data; port i at bits [i*XLEN +: XLEN].
  rd_busy  out  NRD  scoreboard busy bit of each read address.
  wr_en  in  1  write strobe.
  wr_addr  in  AW  write address.
  wr_data  in  XLEN  write data.
  alloc_en  in  1  mark a destination register pending.
  alloc_addr  in  AW  register to mark pending.
  clr_req  in  1  start a full-file clear sweep.
  ready  out  1  high when in IDLE; file accepts writes and allocs.
  clr_done  out  1  one-cycle pulse when a sweep completes.

Function
REQ-006 Register 0 SHALL always read 0 with rd_busy 0; writes and allocs to it SHALL be ignored.
REQ-007 Reads SHALL be combinational: rd_data[i] = reg[rd_addr[i]], rd_busy[i] = busy[rd_addr[i]].
REQ-008 With ready=1 and wr_en=1, reg[wr_addr] SHALL take wr_data and busy[wr_addr] SHALL clear at the next posedge.
REQ-009 With ready=1 and alloc_en=1, busy[alloc_addr] SHALL be set at the next posedge.
REQ-010 Same-cycle alloc and write to the same address: data SHALL be written and busy SHALL end 1 (alloc wins).
REQ-011 Multiple read ports addressing the same register SHALL return identical data.
REQ-012 FSM states: IDLE, CLEAR. IDLE -> CLEAR when clr_req=1; CLEAR -> IDLE after index NREGS-1 is cleared.
REQ-013 In CLEAR, one register per cycle SHALL be zeroed, index 0 to NREGS-1, and its busy bit cleared; sweep lasts exactly NREGS cycles.
REQ-014 In CLEAR, wr_en, alloc_en and clr_req SHALL be ignored; ready SHALL be 0.
REQ-015 clr_done SHALL pulse high for the single cycle after the last index is cleared, coinciding with the first cycle of ready=1.
REQ-016 In CLEAR, reads SHALL return current array contents (already-swept entries read 0).
REQ-017 clr_req asserted in IDLE together with wr_en/alloc_en: the write/alloc SHALL take effect, then the sweep SHALL start.

Reset
REQ-018 rst=1 SHALL immediately clear all busy bits, set the sweep index to 0, force clr_done=0 and enter CLEAR.
REQ-019 After rst deasserts, the file SHALL complete a full NREGS-cycle sweep before ready rises; register contents are undefined until then.
REQ-020 rst asserted mid-sweep SHALL restart the sweep from index 0.

Configuration
REQ-021 Macro REG_FILE_SB_BYPASS_EN defined: when ready=1, wr_en=1, wr_addr!=0 and rd_addr[i]==wr_addr, rd_data[i] SHALL equal wr_data and rd_busy[i] SHALL be 0 (unless alloc_en targets the same address, then 1) in the same cycle.
REQ-022 Macro REG_FILE_SB_BYPASS_EN undefined: reads SHALL return the stored value and busy bit; the new value is visible the cycle after the write.

Verification
REQ-023 Reset, NREGS=32: rst pulse -> ready=0 for 32 cycles, clr_done pulses once, all rd_data=0, all rd_busy=0.
REQ-024 Write 0xDEADBEEF to r5, then read r5 on both ports -> both return 0xDEADBEEF; write to r0 -> r0 still reads 0.
REQ-025 alloc r7, read r7 -> rd_busy=1; next cycle write r7=0x12 -> rd_busy=0, data 0x12; alloc+write r7 same cycle -> busy stays 1.
REQ-026 Bypass: write r3=0xA5A5A5A5 with rd_addr0=r3 same cycle -> with macro 0xA5A5A5A5/busy 0; without macro old value until next cycle.
REQ-027 clr_req after filling r1..r31 with nonzero data; wr_en r9 mid-sweep ignored; rst at sweep cycle 10 -> sweep restarts, totals 32 cycles after rst, all registers read 0.
